// File: rtl/vga_frame_monitor.sv
// Receive-side VGA timing monitor: rebuilds pixel coordinates from sync edges, verifies
// line/frame lengths, counts lit pixels per frame and captures the colour at a probe point.
module vga_frame_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int X_OFS    = 144,
  parameter int Y_OFS    = 35,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [2:0]  rgb,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        locked,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic        frame_done,
  output logic [18:0] lit_count,
  output logic [2:0]  probe_rgb,
  output logic [7:0]  err_count
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [9:0]  XO = 10'(X_OFS);
  localparam logic [9:0]  XE = 10'(X_OFS + H_ACTIVE);
  localparam logic [9:0]  YO = 10'(Y_OFS);
  localparam logic [9:0]  YE = 10'(Y_OFS + V_ACTIVE);
  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [10:0] VT = 11'(V_TOTAL);

  logic        s_h_q, s_v_q, s_h_prev_q, s_v_prev_q;
  logic [2:0]  s_rgb_q;
  logic [9:0]  hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic        vpend_q, vpend_d;
  logic [1:0]  state_q, state_d;
  logic        acq_err_q, acq_err_d;
  logic [18:0] lit_acc_q, lit_acc_d, lit_count_q, lit_count_d;
  logic [2:0]  shadow_q, shadow_d, probe_rgb_q, probe_rgb_d;
  logic [7:0]  err_q, err_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;

  logic hfall, vfall, bnd, line_bad, frame_bad, any_bad;
  logic active_d, lit_now, accept, err_inc;

  // Counters and coordinates describe the sample currently held in s_h/s_v/s_rgb.
  always_comb begin
    hfall     = s_h_prev_q & ~s_h_q;
    vfall     = s_v_prev_q & ~s_v_q;
    bnd       = hfall & (vpend_q | vfall);
    line_bad  = hfall & (({1'b0, hcnt_q} + 11'd1) != HT);
    frame_bad = bnd & (({1'b0, lcnt_q} + 11'd1) != VT);
    any_bad   = line_bad | frame_bad;

    hcnt_d = hcnt_q;
    if (hfall)                hcnt_d = '0;
    else if (hcnt_q != 10'h3ff) hcnt_d = hcnt_q + 10'd1;

    lcnt_d  = lcnt_q;
    vpend_d = vpend_q | vfall;
    if (bnd) begin
      lcnt_d  = '0;
      vpend_d = 1'b0;
    end else if (hfall && lcnt_q != 10'h3ff) begin
      lcnt_d = lcnt_q + 10'd1;
    end

    pix_x_d  = hcnt_d - XO;
    pix_y_d  = lcnt_d - YO;
    active_d = (hcnt_d >= XO) && (hcnt_d < XE) && (lcnt_d >= YO) && (lcnt_d < YE);
    lit_now  = active_d && (s_rgb_q != 3'b000);
  end

  always_comb begin
    state_d   = state_q;
    acq_err_d = acq_err_q;
    accept    = 1'b0;
    err_inc   = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (bnd) begin
          state_d   = ST_ACQUIRE;
          acq_err_d = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        if (bnd) begin
          acq_err_d = 1'b0;
          if (!(acq_err_q || any_bad)) begin
            state_d = ST_LOCKED;
            accept  = 1'b1;
          end
        end else if (any_bad) begin
          acq_err_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (any_bad) begin
          state_d = ST_SEARCH;
          err_inc = 1'b1;
        end else if (bnd) begin
          accept = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    lit_acc_d = lit_acc_q;
    if (bnd)
      lit_acc_d = (accept && lit_now) ? 19'd1 : 19'd0;
    else if (state_q != ST_SEARCH && lit_now)
      lit_acc_d = lit_acc_q + 19'd1;

    lit_count_d = accept ? lit_acc_q : lit_count_q;
    shadow_d    = (active_d && pix_x_d == probe_x && pix_y_d == probe_y) ? s_rgb_q : shadow_q;
    probe_rgb_d = accept ? shadow_q : probe_rgb_q;
    err_d       = (err_inc && err_q != 8'hff) ? err_q + 8'd1 : err_q;

    frame_done_d = accept;
    pix_valid_d  = active_d && (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_h_q        <= 1'b1;
      s_v_q        <= 1'b1;
      s_h_prev_q   <= 1'b1;
      s_v_prev_q   <= 1'b1;
      s_rgb_q      <= '0;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      vpend_q      <= 1'b0;
      state_q      <= ST_SEARCH;
      acq_err_q    <= 1'b0;
      lit_acc_q    <= '0;
      lit_count_q  <= '0;
      shadow_q     <= '0;
      probe_rgb_q  <= '0;
      err_q        <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      s_h_q        <= h_sync;
      s_v_q        <= v_sync;
      s_h_prev_q   <= s_h_q;
      s_v_prev_q   <= s_v_q;
      s_rgb_q      <= rgb;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      vpend_q      <= vpend_d;
      state_q      <= state_d;
      acq_err_q    <= acq_err_d;
      lit_acc_q    <= lit_acc_d;
      lit_count_q  <= lit_count_d;
      shadow_q     <= shadow_d;
      probe_rgb_q  <= probe_rgb_d;
      err_q        <= err_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;
  assign lit_count  = lit_count_q;
  assign probe_rgb  = probe_rgb_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor on a shrunken 40x24 raster with an 11x11 icon;
// expected frame_done results are queued by the stimulus and popped by a monitor thread.
module tb_vga_frame_monitor;
  localparam int H_T = 40, V_T = 24, XO = 8, YO = 3, HA = 24, VA = 18;
  localparam int HS_W = 4, VS_W = 2;

  typedef struct {
    int lit;
    int prb;
    int err;
  } exp_t;

  logic       clk = 1'b0, reset = 1'b1;
  logic       h_sync = 1'b1, v_sync = 1'b1;
  logic [2:0] rgb = '0;
  logic [9:0] probe_x = 10'd10, probe_y = 10'd9;
  logic       locked, pix_valid, frame_done;
  logic [9:0] pix_x, pix_y;
  logic [18:0] lit_count;
  logic [2:0] probe_rgb;
  logic [7:0] err_count;

  int   checks = 0, fails = 0;
  exp_t exp_q[$];

  vga_frame_monitor #(
    .H_TOTAL(H_T), .V_TOTAL(V_T), .X_OFS(XO), .Y_OFS(YO), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .rgb(rgb),
    .probe_x(probe_x), .probe_y(probe_y), .locked(locked), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .frame_done(frame_done), .lit_count(lit_count),
    .probe_rgb(probe_rgb), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Icon at active (5..15, 4..14); lit pixels just outside the active window must not count.
  function automatic logic [2:0] color(input int hp, input int ln, input bit icon);
    if (!icon) return 3'd0;
    if (hp >= XO + 5 && hp <= XO + 15 && ln >= YO + 4 && ln <= YO + 14) return 3'd7;
    if (hp == XO - 1 || hp == XO + HA || ln == YO - 1 || ln == YO + VA) return 3'd1;
    return 3'd0;
  endfunction

  task automatic line(input int ln, input int len, input bit icon, input int start);
    for (int hp = start; hp < len; hp++) begin
      @(negedge clk);
      h_sync = (hp >= HS_W);
      v_sync = (ln >= VS_W);
      rgb    = color(hp, ln, icon);
    end
  endtask

  task automatic lines(input int from, input int to, input bit icon, input int short_ln);
    for (int ln = from; ln < to; ln++)
      line(ln, (ln == short_ln) ? H_T - 1 : H_T, icon, 0);
  endtask

  task automatic push(input int lit, input int prb, input int err);
    exp_t e;
    e.lit = lit; e.prb = prb; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " locked"},     int'(locked),     0);
    chk({tag, " pix_x"},      int'(pix_x),      0);
    chk({tag, " pix_y"},      int'(pix_y),      0);
    chk({tag, " pix_valid"},  int'(pix_valid),  0);
    chk({tag, " frame_done"}, int'(frame_done), 0);
    chk({tag, " lit_count"},  int'(lit_count),  0);
    chk({tag, " probe_rgb"},  int'(probe_rgb),  0);
    chk({tag, " err_count"},  int'(err_count),  0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (frame_done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected frame_done", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("done lit_count", int'(lit_count), e.lit);
            chk("done probe_rgb", int'(probe_rgb), e.prb);
            chk("done err_count", int'(err_count), e.err);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Partial frame 1 (starts mid-raster): its closing boundary only leaves SEARCH.
    line(3, H_T, 1'b0, 20);
    lines(4, V_T, 1'b0, -1);

    // Frame 2 clean and blank: lock at its end with zero lit pixels.
    push(0, 0, 0);
    lines(0, 1, 1'b0, -1);
    chk("acquire locked", int'(locked), 0);
    lines(1, V_T, 1'b0, -1);

    // Frames 3,4: icon drawn, probe at (10,9) inside it.
    lines(0, 1, 1'b1, -1);
    chk("frame3 locked", int'(locked), 1);
    push(121, 7, 0);
    lines(1, V_T, 1'b1, -1);
    push(121, 7, 0);
    lines(0, 8, 1'b1, -1);
    chk("pix_x right edge", int'(pix_x), 29);
    chk("pix_y right edge", int'(pix_y), 4);
    chk("pix_valid right edge", int'(pix_valid), 0);
    line(8, 20, 1'b1, 0);
    chk("pix_x mid", int'(pix_x), 9);
    chk("pix_y mid", int'(pix_y), 5);
    chk("pix_valid mid", int'(pix_valid), 1);
    line(8, H_T, 1'b1, 20);
    lines(9, V_T, 1'b1, -1);

    // Frame 5: probe moved to (0,0) before the active area starts.
    push(121, 0, 0);
    lines(0, 1, 1'b1, -1);
    probe_x = 10'd0;
    probe_y = 10'd0;
    lines(1, V_T, 1'b1, -1);

    // Frame 6: line 10 is one clock short.
    lines(0, 11, 1'b1, 10);
    chk("short pre locked", int'(locked), 1);
    lines(11, 12, 1'b1, -1);
    chk("short locked", int'(locked), 0);
    chk("short err_count", int'(err_count), 1);
    chk("short lit held", int'(lit_count), 121);
    lines(12, V_T, 1'b1, -1);

    // Frame 7 reacquires.
    push(121, 0, 1);
    lines(0, 1, 1'b1, -1);
    chk("reacq locked", int'(locked), 0);
    lines(1, V_T, 1'b1, -1);

    // Frame 8 is one line short: rejected with no frame_done.
    lines(0, 1, 1'b1, -1);
    chk("frame8 locked", int'(locked), 1);
    lines(1, V_T - 1, 1'b1, -1);
    lines(0, 1, 1'b1, -1);
    chk("bad frame locked", int'(locked), 0);
    chk("bad frame err_count", int'(err_count), 2);
    lines(1, V_T, 1'b1, -1);
    push(121, 0, 2);
    lines(0, V_T, 1'b1, -1);

    // Frame 11: reset at line 12.
    lines(0, 1, 1'b1, -1);
    chk("frame11 locked", int'(locked), 1);
    lines(1, 12, 1'b1, -1);
    @(negedge clk);
    reset = 1'b1;
    probe_x = 10'd10;
    probe_y = 10'd9;
    #1;
    chk_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    lines(12, V_T, 1'b1, -1);
    push(121, 7, 0);
    lines(0, 1, 1'b1, -1);
    chk("post reset acquire", int'(locked), 0);
    lines(1, V_T, 1'b1, -1);
    lines(0, 2, 1'b1, -1);
    chk("post reset relock", int'(locked), 1);

    repeat (4) @(negedge clk);
    chk("pending frame_done", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
